// File: rtl/fft_pkg.sv
// Shared encodings and default sizes for the FFT datapath and its stimulus source.
package fft_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_FFT_N  = 64;
    localparam int DEF_LOG2_N = 6;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        MODE_RAMP = 2'd0,
        MODE_IMP  = 2'd1,
        MODE_DC   = 2'd2,
        MODE_ALT  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fft_stim_pattern.sv
// Combinational pattern value for sample index k; the top registers the result.
module fft_stim_pattern
    import fft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic [1:0]        mode,
    input  logic [LOG2_N-1:0] k,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] amp,
    output logic [DATA_W-1:0] value
);

    // NOTE: assign a default first so every path through the case drives value (no latch).
    always_comb begin
        value = '0;
        case (mode_e'(mode))
            MODE_RAMP: value = acc;
            MODE_IMP:  value = (k == '0) ? amp : '0;
            MODE_DC:   value = amp;
            // Two's-complement negation keeps the most-negative value unchanged.
            MODE_ALT:  value = k[0] ? (~amp + 1'b1) : amp;
            default:   value = '0;
        endcase
    end

endmodule

// File: rtl/fft_stim_gen.sv
// Frame source for FFT self-test: ramp/impulse/DC/alternating frames over valid/ready.
module fft_stim_gen
    import fft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FFT_N  = DEF_FFT_N,
    parameter int LOG2_N = DEF_LOG2_N,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] amp,
    input  logic [DATA_W-1:0] step,
    input  logic              ramp_cont,
    input  logic [CNT_W-1:0]  num_frames,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_i,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              done
);

    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(FFT_N - 1);

    state_e             state_q, state_d;
    logic [LOG2_N-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]   frames_q, frames_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               stop_seen_q, stop_seen_d;

    logic [1:0]         mode_q, mode_d;
    logic [DATA_W-1:0]  amp_q, amp_d;
    logic [DATA_W-1:0]  step_q, step_d;
    logic               ramp_cont_q, ramp_cont_d;
    logic [CNT_W-1:0]   num_frames_q, num_frames_d;

    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_r_q, out_r_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               hs;
    logic               last_idx;
    logic               last_frame;
    logic               finish;
    logic               load;
    logic [DATA_W-1:0]  pat_value;

    assign hs         = out_valid_q & out_ready;
    assign last_idx   = (idx_q == LAST_IDX);
    assign last_frame = (num_frames_q != '0) && ((frames_q + 1'b1) == num_frames_q);
    // A stop arriving on the eop handshake itself still ends the stream after this frame.
    assign finish     = hs & last_idx & (last_frame | stop_seen_q | stop);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frames_d     = frames_q;
        acc_d        = acc_q;
        stop_seen_d  = stop_seen_q;
        mode_d       = mode_q;
        amp_d        = amp_q;
        step_d       = step_q;
        ramp_cont_d  = ramp_cont_q;
        num_frames_d = num_frames_q;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    mode_d       = mode;
                    amp_d        = amp;
                    step_d       = step;
                    ramp_cont_d  = ramp_cont;
                    num_frames_d = num_frames;
                    idx_d        = '0;
                    frames_d     = '0;
                    acc_d        = amp;
                    stop_seen_d  = 1'b0;
                    load         = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) stop_seen_d = 1'b1;
                if (finish) begin
                    state_d     = ST_DONE;
                    stop_seen_d = 1'b0;
                    idx_d       = '0;
                    frames_d    = '0;
                end else if (hs) begin
                    idx_d = idx_q + 1'b1;
                    acc_d = acc_q + step_q;
                    if (last_idx) begin
                        frames_d = frames_q + 1'b1;
                        if (!ramp_cont_q) acc_d = amp_q;
                    end
                    load = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    fft_stim_pattern #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_pattern (
        .mode  (mode_d),
        .k     (idx_d),
        .acc   (acc_d),
        .amp   (amp_d),
        .value (pat_value)
    );

    // Output registers: new sample on load, hold while stalled, clear outside RUN.
    always_comb begin
        out_valid_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        out_r_d     = out_r_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        if (load) begin
            out_r_d   = pat_value;
            out_sop_d = (idx_d == '0);
            out_eop_d = (idx_d == LAST_IDX);
        end else if (state_d != ST_RUN) begin
            out_r_d   = '0;
            out_sop_d = 1'b0;
            out_eop_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            frames_q     <= '0;
            acc_q        <= '0;
            stop_seen_q  <= 1'b0;
            mode_q       <= '0;
            amp_q        <= '0;
            step_q       <= '0;
            ramp_cont_q  <= 1'b0;
            num_frames_q <= '0;
            out_valid_q  <= 1'b0;
            out_r_q      <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frames_q     <= frames_d;
            acc_q        <= acc_d;
            stop_seen_q  <= stop_seen_d;
            mode_q       <= mode_d;
            amp_q        <= amp_d;
            step_q       <= step_d;
            ramp_cont_q  <= ramp_cont_d;
            num_frames_q <= num_frames_d;
            out_valid_q  <= out_valid_d;
            out_r_q      <= out_r_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_i     = '0;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fft_stim_gen.sv
// Self-checking bench for fft_stim_gen: table of stream configurations plus stop/reset corner cases.
module tb_fft_stim_gen;

    localparam int DW = 16;
    localparam int N  = 64;
    localparam int LN = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, ramp_cont, out_ready;
    logic [1:0]    mode;
    logic [DW-1:0] amp, step;
    logic [CW-1:0] num_frames;
    logic          out_valid, out_sop, out_eop, busy, done;
    logic [DW-1:0] out_r, out_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_stim_gen #(.DATA_W(DW), .FFT_N(N), .LOG2_N(LN), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .amp        (amp),
        .step       (step),
        .ramp_cont  (ramp_cont),
        .num_frames (num_frames),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_i      (out_i),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: sample value from the pattern rules, using global sample position for ramps.
    function automatic logic signed [15:0] model(input logic [1:0] m, input logic signed [15:0] a,
                                                 input logic signed [15:0] s, input logic rc,
                                                 input int frame, input int k);
        int pos;
        int t;
        pos = rc ? frame * N + k : k;
        case (m)
            2'd0:    t = int'(a) + int'(s) * pos;
            2'd1:    t = (k == 0) ? int'(a) : 0;
            2'd2:    t = int'(a);
            default: t = (k % 2 == 1) ? -int'(a) : int'(a);
        endcase
        return t[15:0];
    endfunction

    task automatic run_stream(input logic [1:0] m, input logic [15:0] a, input logic [15:0] s,
                              input logic rc, input logic [7:0] nf, input int ready_pct,
                              input int stop_frame, input int stop_k, input int exp_frames,
                              input bit poke_start);
        int frame, k, cycles, hs_count;
        bit stalled;
        logic [17:0] held;
        frame = 0; k = 0; cycles = 0; hs_count = 0; stalled = 1'b0; held = '0;
        @(negedge clk);
        mode = m; amp = a; step = s; ramp_cont = rc; num_frames = nf;
        start = 1'b1; stop = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        // Scramble config inputs: the DUT must run from its latched copy.
        mode = 2'($urandom); amp = 16'($urandom); step = 16'($urandom);
        ramp_cont = 1'($urandom); num_frames = 8'($urandom);
        check("busy_after_start", busy, 1);
        while (hs_count < exp_frames * N && cycles < 20000) begin
            if (stalled) check("stall_hold", {out_r, out_sop, out_eop}, held);
            check("valid_in_run", out_valid, 1);
            out_ready = ($urandom_range(0, 99) < ready_pct);
            stop      = (frame == stop_frame && k == stop_k);
            start     = poke_start && (hs_count == 70);
            if (out_valid && out_ready) begin
                check("sample_r", $signed(out_r), model(m, a, s, rc, frame, k));
                check("sample_i", out_i, 0);
                check("sop", out_sop, (k == 0));
                check("eop", out_eop, (k == N - 1));
                hs_count++;
                k++;
                if (k == N) begin
                    k = 0;
                    frame++;
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_r, out_sop, out_eop};
            @(negedge clk);
            cycles++;
        end
        stop = 1'b0; start = 1'b0;
        check("handshake_count", hs_count, exp_frames * N);
        check("done_pulse", done, 1);
        check("valid_after_done", out_valid, 0);
        check("busy_after_done", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_valid", out_valid, 0);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [15:0] a;
        logic [15:0] s;
        logic        rc;
        logic [7:0]  nf;
        int          rp;
        int          ef;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd0, 16'd0,     16'd1, 1'b1, 8'd2, 100, 2};
        vecs[1] = '{2'd1, 16'd1000,  16'd0, 1'b1, 8'd1, 50,  1};
        vecs[2] = '{2'd3, 16'h8000,  16'd0, 1'b1, 8'd1, 100, 1};
        vecs[3] = '{2'd2, 16'd5,     16'd0, 1'b1, 8'd1, 100, 1};
        vecs[4] = '{2'd0, 16'd32760, 16'd4, 1'b0, 8'd2, 100, 2};
        vecs[5] = '{2'd0, 16'($urandom), 16'($urandom), 1'b1, 8'd3, 60, 3};
        vecs[6] = '{2'd3, 16'($urandom), 16'd0, 1'b0, 8'd1, 30, 1};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = '0; amp = '0; step = '0;
        ramp_cont = 1'b0; num_frames = '0; out_ready = 1'b0;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sop_eop", {out_sop, out_eop}, 0);
        check("rst_data", {out_r, out_i}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_stream(vecs[i].m, vecs[i].a, vecs[i].s, vecs[i].rc, vecs[i].nf,
                       vecs[i].rp, -1, -1, vecs[i].ef, 1'b0);

        // Continuous ramp, stop at sample 10 of frame 3, stray start mid-run.
        run_stream(2'd0, 16'd100, 16'hFFFD, 1'b1, 8'd0, 100, 2, 10, 3, 1'b1);
        // Stop coincident with the eop handshake of the first frame.
        run_stream(2'd2, 16'd7, 16'd0, 1'b1, 8'd0, 100, 0, N - 1, 1, 1'b0);

        // Stop while idle must not carry into the next run.
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        run_stream(2'd2, 16'hFFF0, 16'd0, 1'b1, 8'd2, 100, -1, -1, 2, 1'b0);

        // Reset in the middle of a frame, then restart from index 0.
        @(negedge clk);
        mode = 2'd0; amp = 16'd0; step = 16'd1; ramp_cont = 1'b1; num_frames = 8'd0;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_k20", $signed(out_r), 20);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_data", out_r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(2'd0, 16'd0, 16'd1, 1'b1, 8'd1, 100, -1, -1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stim_gen.md
Name: fft_stim_gen

Overview:
Synthesizable, parametrised frame source that drives complex samples into the FFT datapath (fft_64p_unit and larger-N successors) for on-chip self-test and bring-up.
It generates N-point frames in one of four patterns: ramp, impulse, DC or alternating. Output uses a valid/ready handshake with start/end-of-frame markers. A start/done control interface supports a programmable frame count or continuous streaming.

Parameters:
DATA_W, 16, signed sample width for real and imaginary parts
FFT_N, 64, samples per frame; power of two, 8..4096
LOG2_N, 6, log2(FFT_N); sizes the sample index
CNT_W, 8, width of the frame-count field

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
stop  in  1  level or pulse; ends streaming after the current frame
mode  in  2  pattern: 0 ramp, 1 impulse, 2 DC, 3 alternating
amp  in  DATA_W  signed amplitude / ramp initial value
step  in  DATA_W  signed ramp increment
ramp_cont  in  1  1: ramp continues across frames; 0: ramp restarts at amp every frame
num_frames  in  CNT_W  frames to send; 0 means continuous until stop
out_valid  out  1  sample valid
out_ready  in  1  downstream accept
out_r  out  DATA_W  real sample
out_i  out  DATA_W  imaginary sample; always 0
out_sop  out  1  high with sample index 0
out_eop  out  1  high with sample index FFT_N-1
busy  out  1  high in RUN
done  out  1  one-cycle pulse on completion or stop

Behaviour:
- Reset (async, rst_n=0): state IDLE. out_valid, out_sop, out_eop, busy and done are 0. out_r and out_i are 0. Index, frame counter and ramp accumulator are cleared. Reset asserted mid-frame aborts immediately with no partial-frame flush.
- Config latch: on start in IDLE, latch mode, amp, step, ramp_cont and num_frames. Inputs changing during RUN have no effect.
- start while not IDLE is ignored.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> DONE on a handshake (out_valid & out_ready) of the eop sample when either:
    - num_frames != 0 and frames_sent+1 == num_frames, or
    - stop has been seen (sticky flag, set during RUN, cleared on leaving RUN).
  - DONE -> IDLE unconditionally after 1 cycle. done=1 only in DONE.
- Latency: out_valid rises the cycle after start is sampled. The first sample is index 0 with out_sop=1.
- Handshake:
  - While RUN, out_valid is held at 1.
  - Data, sop and eop are held stable while out_valid & !out_ready.
  - Index advances only on a handshake.
  - out_ready low indefinitely stalls the generator with no loss.
- Index wraps from FFT_N-1 to 0 on handshake; the frame counter increments at that wrap.
- Patterns (per sample k):
  - Ramp: out_r = acc. acc starts at amp and adds step on every handshake, wrapping modulo 2^DATA_W with no saturation. If ramp_cont=0, acc reloads amp at frame wrap.
  - Impulse: out_r = amp at k=0, else 0.
  - DC: out_r = amp for all k.
  - Alternating: out_r = amp at even k, -amp at odd k. Negation is two's complement, so -(most-negative) equals most-negative.
- Simultaneous events:
  - stop and eop handshake in the same cycle -> DONE after this frame.
  - stop while IDLE is ignored.
  - stop in the first frame still completes that full frame.
- No partial frames are ever emitted except on reset.
- Outputs are registered; no combinational path from out_ready to out_valid.

Decomposition:
- Shared package fft_pkg holds:
  - mode encodings MODE_RAMP=0, MODE_IMP=1, MODE_DC=2, MODE_ALT=3
  - FSM state encodings ST_IDLE, ST_RUN, ST_DONE
  - default DATA_W/FFT_N constants shared with the FFT units
- One natural sub-module, fft_stim_pattern: combinational/registered pattern value from (mode, k, acc, amp). The FSM, counters and handshake stay in the top.

Test Plan:
- Ramp, amp=0, step=1, ramp_cont=1, num_frames=2, out_ready=1 -> 128 samples out_r=0..127, sop at k=0 of both frames, eop at samples 63 and 127, done pulse 1 cycle after the last handshake, busy low after.
- Impulse, amp=1000, num_frames=1, out_ready toggled pseudo-randomly -> exactly 64 handshakes, first sample 1000 with sop, rest 0; data held stable on every stalled cycle.
- Alternating, amp=-32768 (DATA_W=16), num_frames=1 -> every sample -32768 (negation wrap); DC amp=5 -> all 64 samples 5.
- Ramp, amp=32760, step=4, ramp_cont=0, num_frames=2 -> wrap 32764 -> -32768 within frame; frame 2 restarts at 32760.
- num_frames=0, stop pulsed at sample 10 of frame 3 -> frame 3 completes to eop, done pulses; start asserted mid-RUN ignored.
- rst_n dropped mid-frame at k=20 -> out_valid/busy 0 asynchronously; after release plus start, output resumes at k=0 with sop.
